// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one right shifter. A round-robin
// arbiter grants one request per cycle into a single-entry result register.
// The shift amount is the low SHAMT_BITS bits of y.
// Optional feature: define SHIFT_ARBITER_SRA_EN to let rN_sra select an
// arithmetic shift. Without it, rN_sra is ignored and every shift is logical.
module shift_arbiter #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_BITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_x,
  input  logic [WIDTH-1:0] r0_y,
  input  logic             r0_sra,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_x,
  input  logic [WIDTH-1:0] r1_y,
  input  logic             r1_sra,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_id,
  output logic [15:0]      done_cnt
);

  logic                  ptr;        // id granted most recently
  logic                  slot_free;
  logic                  grant;
  logic                  sel_id;
  logic [WIDTH-1:0]      sel_x;
  logic [WIDTH-1:0]      sel_y;
  logic [SHAMT_BITS-1:0] shamt;
  logic [WIDTH-1:0]      shifted;

  // A result can be loaded when the slot is empty or is being drained now.
  assign slot_free = !rsp_valid || rsp_ready;

  // Round-robin grant: on contention the id that did not win last time wins.
  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (!rst && slot_free) begin
      if (r0_valid && r1_valid) begin
        r0_ready = ptr;
        r1_ready = !ptr;
      end else begin
        r0_ready = r0_valid;
        r1_ready = r1_valid;
      end
    end
  end

  assign grant  = r0_ready || r1_ready;
  assign sel_id = r1_ready;
  assign sel_x  = sel_id ? r1_x : r0_x;
  assign sel_y  = sel_id ? r1_y : r0_y;
  assign shamt  = sel_y[SHAMT_BITS-1:0];

`ifdef SHIFT_ARBITER_SRA_EN
  logic             sel_sra;
  logic [WIDTH-1:0] sra_res;
  logic             unused_bits;
  assign sel_sra     = sel_id ? r1_sra : r0_sra;
  // Kept in its own assignment so the signed operand is not widened or
  // turned unsigned by the mux context.
  assign sra_res     = $signed(sel_x) >>> shamt;
  assign shifted     = sel_sra ? sra_res : (sel_x >> shamt);
  assign unused_bits = ^{r0_y, r1_y};
`else
  logic unused_bits;
  assign shifted     = sel_x >> shamt;
  assign unused_bits = ^{r0_y, r1_y, r0_sra, r1_sra};
`endif

  // Result slot: load on grant, empty after a hand-off with no new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= 1'b0;
      ptr       <= 1'b1;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_z     <= shifted;
      rsp_id    <= sel_id;
      ptr       <= sel_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Hand-off counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)                          done_cnt <= '0;
    else if (rsp_valid && rsp_ready)  done_cnt <= done_cnt + 16'd1;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and result.
REQ-002 Parameter: SHAMT_BITS, 5, number of low y bits used as shift amount.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: r0_valid  input  1  requester 0 has an operation pending.
REQ-006 Port: r0_ready  output  1  requester 0 operation accepted this cycle (valid&&ready).
REQ-007 Port: r0_x, r0_y  input  WIDTH each  requester 0 operand and shift-amount word.
REQ-008 Port: r0_sra  input  1  requester 0 arithmetic-shift select (used only under SHIFT_ARBITER_SRA_EN).
REQ-009 Port: r1_valid, r1_ready, r1_x, r1_y, r1_sra  same directions, widths and meanings as the r0 ports, for requester 1.
REQ-010 Port: rsp_valid  output  1  result register holds a valid result.
REQ-011 Port: rsp_ready  input  1  consumer accepts the result this cycle.
REQ-012 Port: rsp_z  output  WIDTH  shifted result.
REQ-013 Port: rsp_id  output  1  index of the requester that issued the result.
REQ-014 Port: done_cnt  output  16  count of results handed off (rsp_valid&&rsp_ready); wraps 0xFFFF->0x0000.

Function
REQ-015 The block SHALL own one shared logical right shifter; shift amount = y[SHAMT_BITS-1:0], upper y bits ignored (y=0x20 -> shift 0, y=0xFF -> shift 31).
REQ-016 Output slot SHALL be a single-entry register; slot is free when !rsp_valid || rsp_ready.
REQ-017 When slot is free and at least one rN_valid is high, exactly one request SHALL be granted (rN_ready=1) combinationally in that cycle; otherwise both rN_ready SHALL be 0.
REQ-018 Arbitration SHALL be round-robin: pointer holds last granted id; on contention the other id wins; with one requester valid it wins regardless of pointer.
REQ-019 Granted operation's result, id SHALL appear on rsp_z/rsp_id with rsp_valid=1 on the next rising edge (latency 1 cycle).
REQ-020 Throughput SHALL be one operation per cycle while rsp_ready=1 (hand-off and new grant in the same cycle).
REQ-021 While rsp_valid=1 and rsp_ready=0, rsp_z, rsp_id SHALL hold stable and both rN_ready SHALL be 0.
REQ-022 rsp_valid SHALL drop to 0 after hand-off if no grant occurred in that cycle.
REQ-023 Requester operands SHALL be sampled only in the grant cycle; later changes SHALL not affect the pending result.
REQ-024 done_cnt SHALL increment by 1 on every cycle with rsp_valid&&rsp_ready.

Reset
REQ-025 While rst=1 at a rising edge: rsp_valid=0, rsp_z=0, rsp_id=0, done_cnt=0, pointer=1 (so r0 wins first contention).
REQ-026 r0_ready and r1_ready SHALL be 0 in any cycle where rst=1.
REQ-027 Reset asserted mid-operation SHALL discard the pending result; no hand-off SHALL be counted in that cycle.

Configuration
REQ-028 With SHIFT_ARBITER_SRA_EN defined, a granted request with rN_sra=1 SHALL shift arithmetically (sign bit x[WIDTH-1] replicated); rN_sra=0 logical.
REQ-029 Without SHIFT_ARBITER_SRA_EN, rN_sra SHALL be ignored and all shifts logical.

Verification
REQ-030 After reset, r0 x=0x12345678 y=0x4, rsp_ready=1 -> r0_ready=1 same cycle; next cycle rsp_valid=1, rsp_z=0x01234567, rsp_id=0, done_cnt=1 after hand-off.
REQ-031 Both valid every cycle after reset, r0 x=0xFFFFFFFF y=0x8, r1 x=0xFFFFFFFF y=0x10 -> results alternate id 0,1,0,1 with z 0x00FFFFFF, 0x0000FFFF.
REQ-032 rsp_ready=0 for 3 cycles with rsp_valid=1 -> rsp_z/rsp_id stable, r0_ready=r1_ready=0, done_cnt unchanged; rsp_ready=1 -> hand-off and new grant same cycle.
REQ-033 y=0x20 -> z=x; y=0xFF with x=0x12345678 -> z=0x00000000; x=0x80000000 y=1 sra=1 -> 0xC0000000 with SHIFT_ARBITER_SRA_EN, 0x40000000 without.
REQ-034 rst pulsed while rsp_valid=1, rsp_ready=0 -> next cycle rsp_valid=0, rsp_z=0, done_cnt=0; first contention afterwards granted to r0.
REQ-035 done_cnt preloaded to 0xFFFF by 65535 hand-offs, one more hand-off -> done_cnt=0x0000.
